// File: rtl/cla_word_sequencer.sv
// Word-wide adder built from a registered 4-bit carry-lookahead stage: operands are
// fed one nibble at a time, LSB first, with the stage carry chained between nibbles.
module cla_word_sequencer #(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 2
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [3:0]       add_x,
    output logic [3:0]       add_y,
    output logic             add_cin,
    input  logic [3:0]       add_z,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_a, w_a_next;
    logic [WIDTH-1:0] r_b, w_b_next;
    logic [IW-1:0]    r_idx, w_idx_next;
    logic [CW-1:0]    r_wait, w_wait_next;
    logic [WIDTH-1:0] r_sum, w_sum_next;
    logic             r_c_out, w_c_out_next;
    logic [3:0]       r_add_x, w_add_x_next;
    logic [3:0]       r_add_y, w_add_y_next;
    logic             r_add_cin, w_add_cin_next;
    logic             r_out_valid, w_out_valid_next;

    logic [IW-1:0]    w_idx_inc;
    logic [3:0]       w_a_nib [N];
    logic [3:0]       w_b_nib [N];

    assign w_idx_inc = r_idx + IW'(1);

    for (genvar gi = 0; gi < N; gi++) begin : g_nib
        assign w_a_nib[gi] = r_a[4*gi +: 4];
        assign w_b_nib[gi] = r_b[4*gi +: 4];
    end

    always_comb begin
        w_state_next     = r_state;
        w_a_next         = r_a;
        w_b_next         = r_b;
        w_idx_next       = r_idx;
        w_wait_next      = r_wait;
        w_sum_next       = r_sum;
        w_c_out_next     = r_c_out;
        w_add_x_next     = r_add_x;
        w_add_y_next     = r_add_y;
        w_add_cin_next   = r_add_cin;
        w_out_valid_next = r_out_valid;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_a_next       = a;
                    w_b_next       = b;
                    w_idx_next     = '0;
                    w_wait_next    = '0;
                    w_add_x_next   = a[3:0];
                    w_add_y_next   = b[3:0];
                    w_add_cin_next = c_in;
                    w_sum_next     = '0;
                    w_state_next   = S_RUN;
                end
            end
            S_RUN: begin
                if (r_wait != CW'(ADD_LAT)) begin
                    w_wait_next = r_wait + CW'(1);
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (r_idx == IW'(i)) begin
                            w_sum_next[4*i +: 4] = add_z;
                        end
                    end
                    if (r_idx == IW'(N - 1)) begin
                        w_c_out_next     = add_cout;
                        w_out_valid_next = 1'b1;
                        w_add_x_next     = '0;
                        w_add_y_next     = '0;
                        w_add_cin_next   = 1'b0;
                        w_state_next     = S_DONE;
                    end else begin
                        // The stage carry-out feeds straight into the next nibble.
                        w_idx_next     = w_idx_inc;
                        w_wait_next    = '0;
                        w_add_x_next   = w_a_nib[w_idx_inc];
                        w_add_y_next   = w_b_nib[w_idx_inc];
                        w_add_cin_next = add_cout;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_out_valid_next = 1'b0;
                    w_state_next     = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_wait      <= '0;
            r_sum       <= '0;
            r_c_out     <= 1'b0;
            r_add_x     <= '0;
            r_add_y     <= '0;
            r_add_cin   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_a         <= w_a_next;
            r_b         <= w_b_next;
            r_idx       <= w_idx_next;
            r_wait      <= w_wait_next;
            r_sum       <= w_sum_next;
            r_c_out     <= w_c_out_next;
            r_add_x     <= w_add_x_next;
            r_add_y     <= w_add_y_next;
            r_add_cin   <= w_add_cin_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign add_x     = r_add_x;
    assign add_y     = r_add_y;
    assign add_cin   = r_add_cin;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Bench for cla_word_sequencer: three configurations run in lock-step, each behind its
// own nibble-adder model, compared every cycle against a word-level arithmetic model.
module tb_cla_word_sequencer;

    localparam int NC = 3;

    function automatic int cfg_w(input int k);
        return (k == 2) ? 4 : 16;
    endfunction

    function automatic int cfg_l(input int k);
        return (k == 1) ? 0 : 2;
    endfunction

    function automatic int cfg_lat(input int k);
        return (cfg_w(k) / 4) * (cfg_l(k) + 1);
    endfunction

    function automatic logic [16:0] wmask(input int k);
        return (17'd1 << cfg_w(k)) - 17'd1;
    endfunction

    logic        clk = 1'b0;
    logic        res;
    logic        in_valid;
    logic        out_ready;
    logic        c_in;
    logic [15:0] a;
    logic [15:0] b;

    logic [15:0] d_sum  [NC];
    logic        d_cout [NC];
    logic        d_ov   [NC];
    logic        d_ir   [NC];
    logic        d_cin  [NC];
    logic [3:0]  d_x    [NC];
    logic [3:0]  d_y    [NC];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NC; gi++) begin : g_cfg
        localparam int W = cfg_w(gi);
        localparam int L = cfg_l(gi);

        logic [W-1:0] s;
        logic [3:0]   ax, ay, az;
        logic         acin, acout, ov, ir, co;
        logic [4:0]   w_f;

        cla_word_sequencer #(.WIDTH(W), .ADD_LAT(L)) u_dut (
            .clk(clk), .res(res),
            .in_valid(in_valid), .in_ready(ir),
            .a(a[W-1:0]), .b(b[W-1:0]), .c_in(c_in),
            .add_x(ax), .add_y(ay), .add_cin(acin),
            .add_z(az), .add_cout(acout),
            .out_valid(ov), .out_ready(out_ready),
            .sum(s), .c_out(co)
        );

        // Nibble adder model: result appears L edges after its inputs.
        assign w_f = {1'b0, ax} + {1'b0, ay} + {4'b0, acin};
        if (L == 0) begin : g_comb
            assign {acout, az} = w_f;
        end else begin : g_pipe
            logic [4:0] pipe [L];
            always @(posedge clk) begin
                pipe[0] <= w_f;
                for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
            end
            assign {acout, az} = pipe[L-1];
        end

        assign d_sum[gi]  = 16'(s);
        assign d_cout[gi] = co;
        assign d_ov[gi]   = ov;
        assign d_ir[gi]   = ir;
        assign d_cin[gi]  = acin;
        assign d_x[gi]    = ax;
        assign d_y[gi]    = ay;
    end

    // Word-level model: busy for N*(ADD_LAT+1) edges, then result held until consumed.
    logic        m_busy  [NC];
    logic        m_valid [NC];
    int          m_edge  [NC];
    logic [16:0] m_res   [NC];
    logic [16:0] m_a     [NC];
    logic [16:0] m_b     [NC];
    logic        m_c     [NC];

    always @(posedge clk or negedge res) begin
        if (!res) begin
            for (int k = 0; k < NC; k++) begin
                m_busy[k]  <= 1'b0;
                m_valid[k] <= 1'b0;
                m_edge[k]  <= 0;
                m_res[k]   <= '0;
                m_a[k]     <= '0;
                m_b[k]     <= '0;
                m_c[k]     <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (m_valid[k]) begin
                    if (out_ready) m_valid[k] <= 1'b0;
                end else if (m_busy[k]) begin
                    m_edge[k] <= m_edge[k] + 1;
                    if (m_edge[k] + 1 == cfg_lat(k)) begin
                        m_busy[k]  <= 1'b0;
                        m_valid[k] <= 1'b1;
                    end
                end else if (in_valid) begin
                    m_busy[k] <= 1'b1;
                    m_edge[k] <= 0;
                    m_a[k]    <= {1'b0, a} & wmask(k);
                    m_b[k]    <= {1'b0, b} & wmask(k);
                    m_c[k]    <= c_in;
                    m_res[k]  <= ({1'b0, a} & wmask(k)) + ({1'b0, b} & wmask(k)) + 17'(c_in);
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cfg%0d: got %h, expected %h at %0t", name, k, act, exp, $time);
    endtask

    task automatic compare_all();
        for (int k = 0; k < NC; k++) begin
            logic [16:0] lowm, ex, ey, ecin;
            int sh;
            chk("in_ready", k, 32'(d_ir[k]), 32'(!m_busy[k] && !m_valid[k]));
            chk("out_valid", k, 32'(d_ov[k]), 32'(m_valid[k]));
            if (m_valid[k]) begin
                chk("sum", k, 32'(d_sum[k]), 32'(m_res[k] & wmask(k)));
                chk("c_out", k, 32'(d_cout[k]), 32'(m_res[k][cfg_w(k)]));
            end
            if (m_busy[k]) begin
                sh   = 4 * (m_edge[k] / (cfg_l(k) + 1));
                lowm = (17'd1 << sh) - 17'd1;
                ex   = (m_a[k] >> sh) & 17'hF;
                ey   = (m_b[k] >> sh) & 17'hF;
                ecin = (sh == 0) ? 17'(m_c[k]) :
                       ((((m_a[k] & lowm) + (m_b[k] & lowm) + 17'(m_c[k])) >> sh) & 17'd1);
                chk("add_x", k, 32'(d_x[k]), 32'(ex));
                chk("add_y", k, 32'(d_y[k]), 32'(ey));
                chk("add_cin", k, 32'(d_cin[k]), 32'(ecin));
            end else if (!m_valid[k]) begin
                chk("idle_add_x", k, 32'(d_x[k]), 32'd0);
                chk("idle_add_y", k, 32'(d_y[k]), 32'd0);
                chk("idle_add_cin", k, 32'(d_cin[k]), 32'd0);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < NC; k++) begin
            chk({tag, "_in_ready"}, k, 32'(d_ir[k]), 32'd1);
            chk({tag, "_out_valid"}, k, 32'(d_ov[k]), 32'd0);
            chk({tag, "_sum"}, k, 32'(d_sum[k]), 32'd0);
            chk({tag, "_c_out"}, k, 32'(d_cout[k]), 32'd0);
            chk({tag, "_add_x"}, k, 32'(d_x[k]), 32'd0);
            chk({tag, "_add_y"}, k, 32'(d_y[k]), 32'd0);
            chk({tag, "_add_cin"}, k, 32'(d_cin[k]), 32'd0);
        end
    endtask

    task automatic run_word(input logic [15:0] ta, input logic [15:0] tb_op, input logic tc,
                            input int hold, input bit lit, input logic [15:0] es,
                            input logic ec, input bit inject);
        int lat [NC];
        bit all_done;
        a = ta; b = tb_op; c_in = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
        for (int k = 0; k < NC; k++) lat[k] = -1;
        for (int cyc = 0; cyc < 64; cyc++) begin
            all_done = 1'b1;
            for (int k = 0; k < NC; k++) begin
                if (lat[k] < 0 && d_ov[k]) lat[k] = cyc;
                if (lat[k] < 0) all_done = 1'b0;
            end
            if (all_done) break;
            in_valid = inject && (cyc >= 1) && (cyc <= 6);
            if (in_valid) begin
                a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
            end
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < NC; k++) chk("latency", k, 32'(lat[k]), 32'(cfg_lat(k)));
        out_ready = 1'b0;
        repeat (hold) tick();
        if (lit) begin
            for (int k = 0; k < 2; k++) begin
                chk("lit_sum", k, 32'(d_sum[k]), 32'(es));
                chk("lit_c_out", k, 32'(d_cout[k]), 32'(ec));
            end
        end
        $display("word a=%h b=%h cin=%0d -> sum=%h/%h/%h c_out=%0d/%0d/%0d lat=%0d/%0d/%0d",
                 ta, tb_op, tc, d_sum[0], d_sum[1], d_sum[2], d_cout[0], d_cout[1], d_cout[2],
                 lat[0], lat[1], lat[2]);
        // Offer a new word on the consuming edge; it must not be taken there.
        out_ready = 1'b1; in_valid = 1'b1;
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < NC; k++) chk("idle_after_consume", k, 32'(d_ir[k]), 32'd1);
        tick();
    endtask

    initial begin
        res = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        res = 1'b1;
        tick();

        run_word(16'h1234, 16'h4321, 1'b0, 0, 1'b1, 16'h5555, 1'b0, 1'b0);
        run_word(16'hFFFF, 16'h0001, 1'b0, 0, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_word(16'h0000, 16'h0000, 1'b1, 0, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_word(16'h8000, 16'h8000, 1'b0, 5, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_word(16'h1111, 16'h2222, 1'b1, 1, 1'b1, 16'h3334, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            run_word(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), 1'b0, 16'h0, 1'b0, i[0]);
        end

        // Abort a word mid-run with reset, then confirm a fresh word still completes.
        a = 16'hABCD; b = 16'h1357; c_in = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        res = 1'b0;
        #1;
        check_reset_outputs("abort");
        tick();
        tick();
        res = 1'b1;
        tick();
        run_word(16'h7FFF, 16'h0001, 1'b1, 2, 1'b1, 16'h8001, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
